// File: rtl/mem_stage.sv
// MIPS memory-access stage: drives the data-memory request port, resolves branches
// and holds the MEM/WB pipeline register. Accesses that run past TIMEOUT are aborted.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [1:0]        wb_in,
  input  logic [2:0]        m_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [4:0]        write_reg_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_err,
  output logic              valid_out,
  output logic [1:0]        wb_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [4:0]        write_reg_out
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [1:0]        wb_q, wb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [4:0]        wreg_q, wreg_d;
  logic              memop;

  assign memop         = valid_in & (m_in[1] | m_in[0]);
  assign pcsrc         = valid_in & m_in[2] & zero_in;
  assign branch_target = pc_in;
  assign stall         = ((state_q == IDLE) & memop) | ((state_q == WAIT) & ~mem_ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    valid_d = valid_q;
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    case (state_q)
      IDLE: begin
        if (memop) begin
          // MemWrite wins when both MemRead and MemWrite are set
          addr_d  = alu_result_in;
          wdata_d = write_data_in;
          we_d    = m_in[0];
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
          valid_d = 1'b0;
          wb_d    = 2'b00;
        end else if (valid_in) begin
          valid_d = 1'b1;
          wb_d    = wb_in;
          alu_d   = alu_result_in;
          wreg_d  = write_reg_in;
        end else begin
          valid_d = 1'b0;
          wb_d    = 2'b00;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          req_d   = 1'b0;
          state_d = IDLE;
          valid_d = 1'b1;
          wb_d    = wb_in;
          alu_d   = alu_result_in;
          wreg_d  = write_reg_in;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          // Squashed write-back; the instruction stays in EX/MEM and retries
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
          valid_d = 1'b1;
          wb_d    = 2'b00;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      wb_q    <= 2'b00;
      rdata_q <= '0;
      alu_q   <= '0;
      wreg_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
    end
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_err        = err_q;
  assign valid_out      = valid_q;
  assign wb_out         = wb_q;
  assign read_data_out  = rdata_q;
  assign alu_result_out = alu_q;
  assign write_reg_out  = wreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB contents are queued at issue time and
// popped by an independent monitor whenever valid_out is seen; port timing is checked inline.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [31:0] pc_in;
  logic        zero_in;
  logic [31:0] alu_result_in;
  logic [31:0] write_data_in;
  logic [4:0]  write_reg_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        mem_err;
  logic        valid_out;
  logic [1:0]  wb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  write_reg_out;

  mem_stage #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .wb_in(wb_in), .m_in(m_in),
    .pc_in(pc_in), .zero_in(zero_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .write_reg_in(write_reg_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .pcsrc(pcsrc),
    .branch_target(branch_target), .mem_err(mem_err), .valid_out(valid_out),
    .wb_out(wb_out), .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wreg;
    bit          full;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = 32'h0;
  int          stall_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] wb, input logic [31:0] rd, input logic [31:0] alu,
                      input logic [4:0] wreg, input bit full);
    exp_t e;
    e.wb = wb; e.rd = rd; e.alu = alu; e.wreg = wreg; e.full = full;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] pc, input logic z, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr);
    valid_in = v; wb_in = wb; m_in = m; pc_in = pc; zero_in = z;
    alu_result_in = alu; write_data_in = wd; write_reg_in = wr;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n === 1'b1 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got valid_out=1 expected no MEM/WB entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_wb_out", 32'(wb_out), 32'(e.wb));
        if (e.full) begin
          check("sb_read_data", read_data_out, e.rd);
          check("sb_alu_result", alu_result_out, e.alu);
          check("sb_write_reg", 32'(write_reg_out), 32'(e.wreg));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_err", 32'(mem_err), 32'(0));
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_valid_out", 32'(valid_out), 32'(0));
    check("rst_wb_out", 32'(wb_out), 32'(0));
    check("rst_read_data", read_data_out, 32'h0);
    check("rst_alu_result", alu_result_out, 32'h0);
    check("rst_write_reg", 32'(write_reg_out), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    #2 reset_n = 1'b1;
    tick();

    // R-type pass-through
    drive(1'b1, 2'b10, 3'b000, 32'h0, 1'b0, 32'h1234, 32'h0, 5'd8);
    #1 check("rtype_stall", 32'(stall), 32'(0));
    push(2'b10, last_rd, 32'h1234, 5'd8, 1'b1);
    tick();
    idle();

    // Load, ready on 3rd WAIT cycle
    drive(1'b1, 2'b11, 3'b010, 32'h0, 1'b0, 32'h100, 32'hAAAA, 5'd3);
    stall_cnt = 0;
    #1 if (stall) stall_cnt++;
    tick();
    check("ld_mem_req", 32'(mem_req), 32'(1));
    check("ld_mem_addr", mem_addr, 32'h100);
    check("ld_mem_we", 32'(mem_we), 32'(0));
    #1 if (stall) stall_cnt++;
    tick();
    #1 if (stall) stall_cnt++;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1 if (stall) stall_cnt++;
    push(2'b11, 32'hDEADBEEF, 32'h100, 5'd3, 1'b1);
    last_rd = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0;
    idle();
    check("ld_stall_cycles", 32'(stall_cnt), 32'(3));
    check("ld_req_drop", 32'(mem_req), 32'(0));

    // Store, zero-wait memory
    drive(1'b1, 2'b00, 3'b001, 32'h0, 1'b0, 32'h20, 32'h55, 5'd0);
    #1 check("st_stall_idle", 32'(stall), 32'(1));
    tick();
    check("st_mem_req", 32'(mem_req), 32'(1));
    check("st_mem_we", 32'(mem_we), 32'(1));
    check("st_mem_wdata", mem_wdata, 32'h55);
    check("st_mem_addr", mem_addr, 32'h20);
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    #1 check("st_stall_wait", 32'(stall), 32'(0));
    push(2'b00, last_rd, 32'h20, 5'd0, 1'b1);
    tick();
    mem_ready = 1'b0;
    idle();
    check("st_req_one_cycle", 32'(mem_req), 32'(0));

    // MemRead and MemWrite both set behaves as a write
    drive(1'b1, 2'b01, 3'b011, 32'h0, 1'b0, 32'h24, 32'h66, 5'd2);
    tick();
    check("rw_mem_we", 32'(mem_we), 32'(1));
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    push(2'b01, last_rd, 32'h24, 5'd2, 1'b1);
    tick();
    mem_ready = 1'b0;
    idle();

    // mem_ready ignored in IDLE
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF0000;
    tick();
    check("idle_req", 32'(mem_req), 32'(0));
    check("idle_valid_out", 32'(valid_out), 32'(0));
    check("idle_wb_out", 32'(wb_out), 32'(0));
    check("idle_read_data", read_data_out, last_rd);
    mem_ready = 1'b0;

    // Branch taken / not taken
    drive(1'b1, 2'b00, 3'b100, 32'h80, 1'b1, 32'h7, 32'h0, 5'd0);
    #1;
    check("br_pcsrc_taken", 32'(pcsrc), 32'(1));
    check("br_target", branch_target, 32'h80);
    check("br_stall_taken", 32'(stall), 32'(0));
    push(2'b00, last_rd, 32'h7, 5'd0, 1'b1);
    tick();
    drive(1'b1, 2'b00, 3'b100, 32'h84, 1'b0, 32'h9, 32'h0, 5'd0);
    #1;
    check("br_pcsrc_not", 32'(pcsrc), 32'(0));
    check("br_target2", branch_target, 32'h84);
    check("br_stall_not", 32'(stall), 32'(0));
    push(2'b00, last_rd, 32'h9, 5'd0, 1'b1);
    tick();
    idle();

    // Timeout (TIMEOUT=4), then successful retry
    drive(1'b1, 2'b11, 3'b010, 32'h0, 1'b0, 32'h44, 32'h0, 5'd7);
    tick();
    check("to_req_rise", 32'(mem_req), 32'(1));
    check("to_err_rise", 32'(mem_err), 32'(0));
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("to_err_early", 32'(mem_err), 32'(0));
      check("to_req_held", 32'(mem_req), 32'(1));
    end
    push(2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    check("to_err_pulse", 32'(mem_err), 32'(1));
    check("to_req_abort", 32'(mem_req), 32'(0));
    check("to_stall_abort", 32'(stall), 32'(1));
    tick();
    check("to_err_one_cycle", 32'(mem_err), 32'(0));
    check("to_req_retry", 32'(mem_req), 32'(1));
    check("to_addr_retry", mem_addr, 32'h44);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    push(2'b11, 32'hCAFEF00D, 32'h44, 5'd7, 1'b1);
    last_rd = 32'hCAFEF00D;
    tick();
    mem_ready = 1'b0;
    idle();
    check("to_err_after", 32'(mem_err), 32'(0));
    check("to_req_after", 32'(mem_req), 32'(0));

    // Reset in the middle of a WAIT
    drive(1'b1, 2'b11, 3'b010, 32'h0, 1'b0, 32'h40, 32'h0, 5'd9);
    tick();
    check("rw_req_before", 32'(mem_req), 32'(1));
    check("rw_addr_before", mem_addr, 32'h40);
    #1;
    reset_n = 1'b0;
    idle();
    #1;
    check("rw_req_async", 32'(mem_req), 32'(0));
    check("rw_stall_async", 32'(stall), 32'(0));
    check("rw_addr_async", mem_addr, 32'h0);
    check("rw_read_data", read_data_out, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    tick();
    check("rw_valid_after", 32'(valid_out), 32'(0));
    check("rw_req_after", 32'(mem_req), 32'(0));
    drive(1'b1, 2'b10, 3'b000, 32'h0, 1'b0, 32'h55AA, 32'h0, 5'd4);
    #1 check("rw_idle_stall", 32'(stall), 32'(0));
    push(2'b10, last_rd, 32'h55AA, 5'd4, 1'b1);
    tick();
    idle();
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
